lcd_timing_sched: RTL
=====================

Name: lcd_timing_sched

Overview:
- Timing controller and frame scheduler for the 800x480 RGB LCD path.
- Derives the pixel clock NCLK from CLK and sequences the panel reset GREST.
- Generates the HD, VD and DEN syncs, plus the pixel coordinates COL/ROW that address the image ROMs.
- Arbitrates image-change requests so the selected image IMG_ID switches only at a frame boundary, with no tearing.

Parameters:
- DIV, 2: CLK cycles per pixel tick (even, >=2).
- H_PW, 1: HD low width, pixel ticks.
- H_BP, 45: horizontal back porch, pixel ticks.
- H_ACT, 800: active pixels per line.
- H_FP, 210: horizontal front porch, pixel ticks.
- V_PW, 1: VD low width, lines.
- V_BP, 22: vertical back porch, lines.
- V_ACT, 480: active lines per frame.
- V_FP, 22: vertical front porch, lines.
- GREST_DLY, 16: pixel ticks GREST is held low after reset.

Ports:
- CLK  in  1  system clock. One clock; reset is synchronous and active-high.
- RST  in  1  synchronous, active-high reset.
- REQ_VALID  in  1  image-change request.
- REQ_ID  in  2  requested image index.
- REQ_READY  out  1  request slot free.
- NCLK  out  1  panel pixel clock.
- GREST  out  1  panel reset, active-low.
- HD  out  1  horizontal sync, active-low.
- VD  out  1  vertical sync, active-low.
- DEN  out  1  data enable.
- COL  out  10  active column 0..799.
- ROW  out  9  active row 0..479.
- IMG_ID  out  2  image currently displayed.
- FRAME_START  out  1  one-CLK pulse at start of each frame.

Behaviour:
- Reset (RST=1 at a CLK edge) values: NCLK=0, GREST=0, HD=1, VD=1, DEN=0, COL=0, ROW=0, IMG_ID=0, FRAME_START=0, REQ_READY=0. Internal state also clears: divider=0, hcnt=0, vcnt=0, pending=0.
- Reset mid-frame aborts the frame immediately; the sequence restarts from INIT.
- Divider:
  - dcnt counts 0..DIV-1.
  - tick=1 when dcnt=DIV-1.
  - NCLK=1 while dcnt >= DIV/2, else 0. The panel therefore samples on the NCLK rising edge mid-pixel.
- State machine:
  - INIT: GREST=0, counters held at 0. Count GREST_DLY ticks, then go to RUN.
  - RUN: GREST=1. On every tick hcnt increments.
    - hcnt wraps at H_TOTAL-1 = H_PW+H_BP+H_ACT+H_FP-1 (1055).
    - On hcnt wrap, vcnt increments; vcnt wraps at V_TOTAL-1 (524).
  - RST returns the machine to INIT.
- Sync and coordinate outputs: all registered, updated in the same CLK cycle the counters update, one cycle after the tick.
  - HD=0 iff hcnt<H_PW. VD=0 iff vcnt<V_PW.
  - hact = hcnt in [H_PW+H_BP, H_PW+H_BP+H_ACT), i.e. [46, 846).
  - vact = vcnt in [V_PW+V_BP, V_PW+V_BP+V_ACT), i.e. [23, 503).
  - DEN = hact & vact.
  - COL = hcnt-(H_PW+H_BP) and ROW = vcnt-(V_PW+V_BP) when DEN=1; both 0 otherwise.
  - In INIT: HD=VD=1, DEN=0.
- Frame start:
  - FRAME_START pulses for one CLK cycle when the counters go to (0,0), including the first entry into RUN.
  - Frame period = H_TOTAL*V_TOTAL*DIV = 1,108,800 CLK cycles.
- Request handshake:
  - A request is accepted in any cycle with REQ_VALID & REQ_READY. REQ_ID is captured into the pending slot, pending=1, and REQ_READY=0 from the next cycle.
  - REQ_READY=1 whenever not in reset and pending=0 (including during INIT).
  - At FRAME_START: if pending=1, IMG_ID<=pending ID, pending<=0, and REQ_READY returns to 1 the next cycle.
  - A request accepted in the same cycle as FRAME_START is not applied; it takes effect at the following frame start.
  - REQ_VALID while REQ_READY=0 is ignored; no overwrite of the pending slot.
- IMG_ID never changes except at FRAME_START or reset.

Test Plan:
- Reset: hold RST 5 cycles -> all outputs at reset values. Release -> GREST=0 for 16*2=32 CLK cycles, then GREST=1 and FRAME_START pulses once.
- Line timing: in RUN, measure the HD period -> 2112 CLK cycles, HD low 2 cycles. DEN rises 92 CLK cycles after the HD falling edge and stays high 1600 cycles on active lines. COL runs 0..799.
- Frame timing: measure VD falling edge to VD falling edge -> 1,108,800 CLK cycles. ROW runs 0..479. Exactly 384,000 pixel ticks have DEN=1 per frame.
- Scheduling: request ID=2 mid-frame -> REQ_READY drops the next cycle. IMG_ID stays 0 until the next FRAME_START, then becomes 2 and REQ_READY=1.
- Collision: request ID=3 in the FRAME_START cycle while pending=0 -> IMG_ID unchanged this frame, becomes 3 at the next FRAME_START. A second request with ID=1 while pending -> ignored, IMG_ID=3.
- Reset mid-frame: assert RST at vcnt=200 -> DEN=0, HD=VD=1, IMG_ID=0 and pending cleared the next cycle. The INIT sequence repeats.

Source files
------------

// File: rtl/lcd_timing_sched.sv
// lcd_timing_sched
//   Timing controller and frame scheduler for an RGB LCD panel (800x480 by
//   default). Divides CLK down to the pixel clock NCLK, holds the panel in
//   reset (GREST low) for GREST_DLY pixel ticks, then free-runs the
//   horizontal/vertical counters that produce HD, VD, DEN and the active
//   pixel coordinates COL/ROW. Image-change requests are parked in a
//   one-deep pending slot and applied only at a frame boundary.
//
// Ports
//   CLK          system clock
//   RST          synchronous, active-high reset
//   REQ_VALID    image-change request
//   REQ_ID       requested image index
//   REQ_READY    pending slot is free
//   NCLK         panel pixel clock (high during the second half of a pixel)
//   GREST        panel reset, active-low
//   HD / VD      horizontal / vertical sync, active-low
//   DEN          data enable
//   COL / ROW    active pixel coordinates, 0 outside the active area
//   IMG_ID       image currently displayed
//   FRAME_START  one-CLK pulse when the counters go to (0,0)
//
// State table
//   S_INIT | GREST low, counters held at 0, counting GREST_DLY pixel ticks
//   S_RUN  | GREST high, hcnt/vcnt advance once per pixel tick
//
// H_PW and V_PW are assumed >= 1, so the (0,0) position is always inside
// the sync pulse and outside the active area.

module lcd_timing_sched #(
    parameter int DIV       = 2,
    parameter int H_PW      = 1,
    parameter int H_BP      = 45,
    parameter int H_ACT     = 800,
    parameter int H_FP      = 210,
    parameter int V_PW      = 1,
    parameter int V_BP      = 22,
    parameter int V_ACT     = 480,
    parameter int V_FP      = 22,
    parameter int GREST_DLY = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       REQ_VALID,
    input  logic [1:0] REQ_ID,
    output logic       REQ_READY,
    output logic       NCLK,
    output logic       GREST,
    output logic       HD,
    output logic       VD,
    output logic       DEN,
    output logic [9:0] COL,
    output logic [8:0] ROW,
    output logic [1:0] IMG_ID,
    output logic       FRAME_START
);

    localparam int H_TOTAL = H_PW + H_BP + H_ACT + H_FP;
    localparam int V_TOTAL = V_PW + V_BP + V_ACT + V_FP;
    localparam int DW      = $clog2(DIV);
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int IW      = $clog2(GREST_DLY + 1);

    localparam logic [DW-1:0] DCNT_LAST = DW'(DIV - 1);
    localparam logic [DW-1:0] DCNT_HALF = DW'(DIV / 2);
    localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_SYNC    = HW'(H_PW);
    localparam logic [HW-1:0] H_ACT_LO  = HW'(H_PW + H_BP);
    localparam logic [HW-1:0] H_ACT_HI  = HW'(H_PW + H_BP + H_ACT);
    localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_SYNC    = VW'(V_PW);
    localparam logic [VW-1:0] V_ACT_LO  = VW'(V_PW + V_BP);
    localparam logic [VW-1:0] V_ACT_HI  = VW'(V_PW + V_BP + V_ACT);
    localparam logic [IW-1:0] INIT_LOAD = IW'(GREST_DLY - 1);

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t        r_state;
    logic [DW-1:0] r_dcnt;
    logic [IW-1:0] r_init_cnt;
    logic [HW-1:0] r_hcnt;
    logic [VW-1:0] r_vcnt;
    logic          r_nclk;
    logic          r_grest;
    logic          r_hd;
    logic          r_vd;
    logic          r_den;
    logic [9:0]    r_col;
    logic [8:0]    r_row;
    logic          r_fs;
    logic          r_pending;
    logic [1:0]    r_pend_id;
    logic [1:0]    r_img;
    logic          r_req_ready;

    logic          w_tick;
    logic [DW-1:0] w_dcnt_nxt;
    logic          w_h_wrap;
    logic [HW-1:0] w_hcnt_nxt;
    logic [VW-1:0] w_vcnt_nxt;
    logic          w_hact;
    logic          w_vact;
    logic          w_accept;

    always_comb begin
        w_tick     = (r_dcnt == DCNT_LAST);
        w_dcnt_nxt = w_tick ? '0 : r_dcnt + 1'b1;
        w_h_wrap   = (r_hcnt == H_LAST);
        w_hcnt_nxt = w_h_wrap ? '0 : r_hcnt + 1'b1;
        w_vcnt_nxt = r_vcnt;
        if (w_h_wrap) begin
            w_vcnt_nxt = (r_vcnt == V_LAST) ? '0 : r_vcnt + 1'b1;
        end
        // Syncs are decoded from the next counter values so that the
        // registered outputs line up with the counters they describe.
        w_hact   = (w_hcnt_nxt >= H_ACT_LO) && (w_hcnt_nxt < H_ACT_HI);
        w_vact   = (w_vcnt_nxt >= V_ACT_LO) && (w_vcnt_nxt < V_ACT_HI);
        w_accept = REQ_VALID & r_req_ready;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= S_INIT;
            r_dcnt      <= '0;
            r_init_cnt  <= INIT_LOAD;
            r_hcnt      <= '0;
            r_vcnt      <= '0;
            r_nclk      <= 1'b0;
            r_grest     <= 1'b0;
            r_hd        <= 1'b1;
            r_vd        <= 1'b1;
            r_den       <= 1'b0;
            r_col       <= '0;
            r_row       <= '0;
            r_fs        <= 1'b0;
            r_pending   <= 1'b0;
            r_pend_id   <= '0;
            r_img       <= '0;
            r_req_ready <= 1'b0;
        end else begin
            r_dcnt <= w_dcnt_nxt;
            r_nclk <= (w_dcnt_nxt >= DCNT_HALF);
            r_fs   <= 1'b0;

            case (r_state)
                S_INIT: begin
                    if (w_tick) begin
                        if (r_init_cnt == '0) begin
                            // First frame starts at (0,0): inside both sync
                            // pulses, outside the active area.
                            r_state <= S_RUN;
                            r_grest <= 1'b1;
                            r_hcnt  <= '0;
                            r_vcnt  <= '0;
                            r_hd    <= 1'b0;
                            r_vd    <= 1'b0;
                            r_den   <= 1'b0;
                            r_col   <= '0;
                            r_row   <= '0;
                            r_fs    <= 1'b1;
                        end else begin
                            r_init_cnt <= r_init_cnt - 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (w_tick) begin
                        r_hcnt <= w_hcnt_nxt;
                        r_vcnt <= w_vcnt_nxt;
                        r_hd   <= (w_hcnt_nxt >= H_SYNC);
                        r_vd   <= (w_vcnt_nxt >= V_SYNC);
                        r_den  <= w_hact & w_vact;
                        r_col  <= (w_hact & w_vact) ? 10'(w_hcnt_nxt - H_ACT_LO) : '0;
                        r_row  <= (w_hact & w_vact) ? 9'(w_vcnt_nxt - V_ACT_LO) : '0;
                        r_fs   <= (w_hcnt_nxt == '0) && (w_vcnt_nxt == '0);
                    end
                end
            endcase

            // Pending image is applied during the FRAME_START cycle, well
            // before the first active line, so no frame mixes two images.
            // A request accepted in that same cycle waits a full frame.
            if (r_fs && r_pending) begin
                r_img       <= r_pend_id;
                r_pending   <= 1'b0;
                r_req_ready <= 1'b1;
            end else if (w_accept) begin
                r_pending   <= 1'b1;
                r_pend_id   <= REQ_ID;
                r_req_ready <= 1'b0;
            end else begin
                r_req_ready <= ~r_pending;
            end
        end
    end

    assign REQ_READY   = r_req_ready;
    assign NCLK        = r_nclk;
    assign GREST       = r_grest;
    assign HD          = r_hd;
    assign VD          = r_vd;
    assign DEN         = r_den;
    assign COL         = r_col;
    assign ROW         = r_row;
    assign IMG_ID      = r_img;
    assign FRAME_START = r_fs;

endmodule
